hi_ssp_framer: RTL

FPGA-side SSP link engine for the HF modes. It divides `ck_1356meg` into `ssp_clk`, marks word boundaries on `ssp_frame`, and serializes core bytes onto `ssp_din` toward the ARM. It also deserializes ARM bytes arriving on `ssp_dout`. It sits between an HF mode core (e.g. the 14443A path) and the ARM SSC peripheral, and is the FPGA end of the link that the ARM side clocks data against.

---
 rtl/hi_ssp_pkg.sv | 19 +
 rtl/hi_ssp_framer_clk_gen.sv | 54 +++++
 rtl/hi_ssp_framer.sv | 84 ++++++++
 3 files changed

// File: rtl/hi_ssp_pkg.sv
// hi_ssp_pkg: constants and types shared by the HF SSP framer, the HF mode
// cores that feed it, and the benches.
//   SSP_WORD_BITS  bits per SSP word
//   SSP_IDLE_BYTE  byte sent when the core has nothing ready at a word boundary
//   ssp_strobe_t   per-cycle timing strobes from ssp_clk_gen; each strobe
//                  describes the ck_1356meg edge at the end of the current cycle
package hi_ssp_pkg;

  localparam int          SSP_WORD_BITS = 8;
  localparam logic [7:0]  SSP_IDLE_BYTE = 8'h00;

  typedef struct packed {
    logic fall;      // ssp_clk falls on the coming edge (div_cnt wraps)
    logic rise;      // ssp_clk rises on the coming edge
    logic last_bit;  // current bit slot is the last of the word
    logic word_end;  // coming edge closes the word and opens the next
  } ssp_strobe_t;

endpackage

// File: rtl/hi_ssp_framer_clk_gen.sv
// ssp_clk_gen: divides ck_1356meg into the SSP bit clock and tracks the bit
// slot within a word.
//   ck_1356meg  in   sole clock
//   rst_n       in   synchronous active-low reset
//   ssp_clk     out  registered serial clock, high for the second half of a slot
//   strb        out  fall / rise / last_bit / word_end strobes (combinational)
module ssp_clk_gen
  import hi_ssp_pkg::*;
#(
  parameter int CLK_DIV   = 8,
  parameter int WORD_BITS = SSP_WORD_BITS
) (
  input  logic        ck_1356meg,
  input  logic        rst_n,
  output logic        ssp_clk,
  output ssp_strobe_t strb
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WORD_BITS);

  localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE_RISE = DW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST     = BW'(WORD_BITS - 1);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;

  always_comb begin
    strb          = '0;
    strb.fall     = (div_cnt == DIV_LAST);
    strb.rise     = (div_cnt == DIV_PRE_RISE);
    strb.last_bit = (bit_cnt == BIT_LAST);
    strb.word_end = strb.fall && strb.last_bit;
  end

  // Reset parks bit_cnt on the last slot so the first wrap starts word 0 and
  // offers the first load one slot after reset release.
  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= BIT_LAST;
      ssp_clk <= 1'b0;
    end else if (strb.fall) begin
      div_cnt <= '0;
      bit_cnt <= strb.last_bit ? '0 : bit_cnt + 1'b1;
      ssp_clk <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (strb.rise) ssp_clk <= 1'b1;
    end
  end

endmodule

// File: rtl/hi_ssp_framer.sv
// hi_ssp_framer: FPGA end of the HF SSP link. Generates ssp_clk/ssp_frame,
// serializes core bytes onto ssp_din (MSB first) and deserializes ssp_dout,
// full duplex, one byte each way per word.
//   ck_1356meg  in   sole clock
//   rst_n       in   synchronous active-low reset
//   tx_data     in   byte from the mode core
//   tx_valid    in   tx_data valid; sampled only while tx_ready is high
//   tx_ready    out  one-cycle load strobe, once per word
//   rx_data     out  last byte received, held until the next word completes
//   rx_valid    out  one-cycle pulse when rx_data updates
//   ssp_clk     out  serial clock to the ARM
//   ssp_frame   out  high during the first bit slot of each word
//   ssp_din     out  serial data to the ARM
//   ssp_dout    in   serial data from the ARM, changes on ssp_clk falls
module hi_ssp_framer
  import hi_ssp_pkg::*;
#(
  parameter int CLK_DIV   = 8,
  parameter int WORD_BITS = SSP_WORD_BITS
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  input  logic       ssp_dout
);

  ssp_strobe_t strb;
  logic [7:0]  tx_shift;
  logic [7:0]  rx_shift;
  logic        started;

  ssp_clk_gen #(
    .CLK_DIV   (CLK_DIV),
    .WORD_BITS (WORD_BITS)
  ) u_clk_gen (
    .ck_1356meg (ck_1356meg),
    .rst_n      (rst_n),
    .ssp_clk    (ssp_clk),
    .strb       (strb)
  );

  assign tx_ready = strb.word_end && rst_n;
  assign ssp_din  = tx_shift[7];

  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      started   <= 1'b0;
      ssp_frame <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      if (strb.word_end) begin
        tx_shift  <= tx_valid ? tx_data : SSP_IDLE_BYTE;
        started   <= 1'b1;
        ssp_frame <= 1'b1;
      end else if (strb.fall) begin
        tx_shift  <= {tx_shift[6:0], 1'b0};
        ssp_frame <= 1'b0;
      end

      // The slot before the first load is not a real word, so it never
      // produces rx_valid.
      if (strb.rise) begin
        rx_shift <= {rx_shift[6:0], ssp_dout};
        if (strb.last_bit && started) begin
          rx_data  <= {rx_shift[6:0], ssp_dout};
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule
